dev_bridge_arb: RTL and testbench

Two-master device bridge that shares the timer/peripheral bus between the CPU data port (m0) and the DMA/debug port (m1). It decodes addresses to timer0, timer1 and the switch/LED device (dev2), and sequences each access as a fixed three-state transaction. It also registers device interrupt lines into the CP0 HWInt vector. It sits between the memory-stage bus and the device modules.

---
 rtl/dev_bridge_arb_pkg.sv | 25 ++
 rtl/dev_bridge_arb_decode.sv | 36 +++
 rtl/dev_bridge_arb.sv | 189 ++++++++++++++++++
 tb/tb_dev_bridge_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bridge_arb_pkg.sv
// dev_bridge_arb_pkg: shared encodings and default device base addresses
// for the two-master timer/peripheral bridge and its address decoder.
package dev_bridge_arb_pkg;

  // Bridge transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Device select code produced by the address decoder.
  typedef enum logic [1:0] {
    SEL_T0   = 2'b00,
    SEL_T1   = 2'b01,
    SEL_D2   = 2'b10,
    SEL_NONE = 2'b11
  } sel_t;

  // Default 16-byte device windows.
  localparam logic [31:0] T0_BASE = 32'h0000_7F00;
  localparam logic [31:0] T1_BASE = 32'h0000_7F10;
  localparam logic [31:0] D2_BASE = 32'h0000_7F20;

endpackage

// File: rtl/dev_bridge_arb_decode.sv
// dev_addr_decode: combinational map from a byte address to a device
// select code plus a hit flag. A window matches when addr[31:4] equals
// the base's [31:4]. Shared with the DMA engine, so it stays standalone.
module dev_addr_decode
  import dev_bridge_arb_pkg::*;
#(
  parameter logic [31:0] T0 = T0_BASE,
  parameter logic [31:0] T1 = T1_BASE,
  parameter logic [31:0] D2 = D2_BASE
) (
  input  logic [31:0] addr,
  output sel_t        sel,
  output logic        hit
);

  // The word/byte offset inside a window does not affect the decode.
  logic unused_offset;
  assign unused_offset = ^addr[3:0];

  // Priority-free window compare; windows never overlap.
  always_comb begin
    sel = SEL_NONE;
    hit = 1'b0;
    if (addr[31:4] == T0[31:4]) begin
      sel = SEL_T0;
      hit = 1'b1;
    end else if (addr[31:4] == T1[31:4]) begin
      sel = SEL_T1;
      hit = 1'b1;
    end else if (addr[31:4] == D2[31:4]) begin
      sel = SEL_D2;
      hit = 1'b1;
    end
  end

endmodule

// File: rtl/dev_bridge_arb.sv
// dev_bridge_arb: round-robin two-master bridge onto the timer/dev2 bus.
// Each access runs IDLE -> ACCESS -> RESP. Device irqs are registered
// into the HWInt vector independently of the sequencer.
// Build option: DEV_BRIDGE_ERR_EN enables the err response on unmapped
// accesses; without it m0_err/m1_err are tied low.
module dev_bridge_arb
  import dev_bridge_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  output logic        t0_we,
  output logic        t1_we,
  output logic        d2_we,
  input  logic [31:0] t0_rdata,
  input  logic [31:0] t1_rdata,
  input  logic [31:0] d2_rdata,
  input  logic        t0_irq,
  input  logic        t1_irq,
  input  logic        d2_irq,
  output logic [5:0]  hwint
);

  state_t      state_reg, state_next;
  logic        last_grant_reg;   // 0: m0 granted last, 1: m1 granted last
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic        id_reg;           // grantee of the transaction in flight
  logic [5:0]  hwint_reg;
  logic        ack_reg   [2];
  logic [31:0] rdata_reg [2];

  logic        any_req;
  logic        grant_id;
  sel_t        sel;
  logic        hit;
  logic [31:0] sel_rdata;
  logic [31:0] resp_rdata;
  logic        unused_byte;

  assign any_req     = m0_req | m1_req;
  assign unused_byte = ^addr_reg[1:0];

  dev_addr_decode u_decode (
    .addr (addr_reg),
    .sel  (sel),
    .hit  (hit)
  );

  // Round-robin pick: on conflict the master not granted last wins.
  always_comb begin
    grant_id = 1'b0;
    if (m0_req && m1_req) begin
      grant_id = ~last_grant_reg;
    end else if (m1_req) begin
      grant_id = 1'b1;
    end
  end

  // Read-data mux for the decoded device; writes and misses return zero.
  always_comb begin
    sel_rdata = 32'h0;
    case (sel)
      SEL_T0:  sel_rdata = t0_rdata;
      SEL_T1:  sel_rdata = t1_rdata;
      SEL_D2:  sel_rdata = d2_rdata;
      default: sel_rdata = 32'h0;
    endcase
    resp_rdata = (we_reg || !hit) ? 32'h0 : sel_rdata;
  end

  // Sequencer next state and the single-cycle device write strobes.
  // Strobes are masked by reset so a reset landing in ACCESS never writes.
  always_comb begin
    state_next = state_reg;
    t0_we      = 1'b0;
    t1_we      = 1'b0;
    d2_we      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = RESP;
        if (we_reg && !reset) begin
          t0_we = (sel == SEL_T0);
          t1_we = (sel == SEL_T1);
          d2_we = (sel == SEL_D2);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus grant latch of the request fields in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      we_reg         <= 1'b0;
      id_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        addr_reg       <= grant_id ? m1_addr  : m0_addr;
        wdata_reg      <= grant_id ? m1_wdata : m0_wdata;
        we_reg         <= grant_id ? m1_we    : m0_we;
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
    end
  end

  // Per-master response: ack pulses for the RESP cycle, rdata held until
  // that master's next ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    always_ff @(posedge clk) begin
      if (reset) begin
        ack_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= 32'h0;
      end else begin
        ack_reg[gi] <= (state_reg == ACCESS) && (id_reg == 1'(gi));
        if (state_reg == ACCESS && id_reg == 1'(gi)) begin
          rdata_reg[gi] <= resp_rdata;
        end
      end
    end
  end

`ifdef DEV_BRIDGE_ERR_EN
  logic err_reg [2];

  // Unmapped access flags err alongside that master's ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_err
    always_ff @(posedge clk) begin
      if (reset) begin
        err_reg[gi] <= 1'b0;
      end else begin
        err_reg[gi] <= (state_reg == ACCESS) && (id_reg == 1'(gi)) && !hit;
      end
    end
  end

  assign m0_err = err_reg[0];
  assign m1_err = err_reg[1];
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Interrupt lines registered into the CP0 HWInt vector every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwint_reg <= 6'h0;
    end else begin
      hwint_reg <= {3'b000, d2_irq, t1_irq, t0_irq};
    end
  end

  assign m0_ack    = ack_reg[0];
  assign m1_ack    = ack_reg[1];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];
  assign dev_addr  = addr_reg[3:2];
  assign dev_wdata = wdata_reg;
  assign hwint     = hwint_reg;

endmodule

// File: tb/tb_dev_bridge_arb.sv
// tb_dev_bridge_arb: table-driven and randomized check of dev_bridge_arb
// against a behavioural model of the arbitration and address map.
module tb_dev_bridge_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        t0_we, t1_we, d2_we;
  logic [31:0] t0_rdata, t1_rdata, d2_rdata;
  logic        t0_irq, t1_irq, d2_irq;
  logic [5:0]  hwint;

`ifdef DEV_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          r0;
    bit          r1;
    logic [31:0] a0;
    bit          w0;
    logic [31:0] d0;
    logic [31:0] a1;
    bit          w1;
    logic [31:0] d1;
    bit          first;   // expected first grantee (0 = m0)
    logic [2:0]  s0;      // expected {d2,t1,t0} strobes for m0's access
    logic [2:0]  s1;
    logic [31:0] rd0;     // expected rdata with m0's ack
    logic [31:0] rd1;
    bit          u0;      // m0 access is unmapped
    bit          u1;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] hold_rd0 = 32'h0;
  logic [31:0] hold_rd1 = 32'h0;
  bit          last_m1 = 1'b1;
  logic [31:0] dev_rd [3];
  vec_t        tbl [8];

  dev_bridge_arb dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .t0_we(t0_we), .t1_we(t1_we), .d2_we(d2_we),
    .t0_rdata(t0_rdata), .t1_rdata(t1_rdata), .d2_rdata(d2_rdata),
    .t0_irq(t0_irq), .t1_irq(t1_irq), .d2_irq(d2_irq),
    .hwint(hwint)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Address map rule as byte ranges: 0..2 = t0/t1/d2, 3 = unmapped.
  function automatic int win(input logic [31:0] a);
    if (a >= 32'h7F00 && a < 32'h7F10) return 0;
    if (a >= 32'h7F10 && a < 32'h7F20) return 1;
    if (a >= 32'h7F20 && a < 32'h7F30) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 4);
    if (k < 4) return 32'h7F00 + 32'(16 * k) + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
    check({tag, " errs"}, {30'd0, m1_err, m0_err}, 32'd0);
    check({tag, " strobes"}, {29'd0, d2_we, t1_we, t0_we}, 32'd0);
    check({tag, " m0_rdata"}, m0_rdata, 32'd0);
    check({tag, " m1_rdata"}, m1_rdata, 32'd0);
    check({tag, " dev_addr"}, {30'd0, dev_addr}, 32'd0);
    check({tag, " dev_wdata"}, dev_wdata, 32'd0);
    check({tag, " hwint"}, {26'd0, hwint}, 32'd0);
  endtask

  // Apply one vector from IDLE and check every cycle until the last ack.
  task automatic run_vec(input vec_t v);
    bit         second, who, a0e, a1e;
    int         ncyc;
    logic [2:0] exp_strb;
    m0_req = v.r0; m0_addr = v.a0; m0_we = v.w0; m0_wdata = v.d0;
    m1_req = v.r1; m1_addr = v.a1; m1_we = v.w1; m1_wdata = v.d1;
    second = ~v.first;
    ncyc   = (v.r0 && v.r1) ? 5 : 2;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      exp_strb = 3'b000;
      a0e = 1'b0;
      a1e = 1'b0;
      who = (c <= 2) ? v.first : second;
      if (c == 1 || c == 4) begin
        exp_strb = who ? v.s1 : v.s0;
        check("dev_addr", {30'd0, dev_addr}, who ? {30'd0, v.a1[3:2]} : {30'd0, v.a0[3:2]});
        check("dev_wdata", dev_wdata, who ? v.d1 : v.d0);
      end
      if (c == 2 || c == 5) begin
        if (who) a1e = 1'b1;
        else     a0e = 1'b1;
      end
      check("strobes", {29'd0, d2_we, t1_we, t0_we}, {29'd0, exp_strb});
      check("m0_ack", {31'd0, m0_ack}, {31'd0, a0e});
      check("m1_ack", {31'd0, m1_ack}, {31'd0, a1e});
      check("m0_err", {31'd0, m0_err}, {31'd0, a0e & v.u0 & ERR_EN});
      check("m1_err", {31'd0, m1_err}, {31'd0, a1e & v.u1 & ERR_EN});
      if (a0e) begin hold_rd0 = v.rd0; m0_req = 1'b0; end
      if (a1e) begin hold_rd1 = v.rd1; m1_req = 1'b0; end
      if (a0e || a1e) begin
        check("m0_rdata", m0_rdata, hold_rd0);
        check("m1_rdata", m1_rdata, hold_rd1);
      end
    end
    $display("vec r0=%0b a0=%h w0=%0b r1=%0b a1=%h w1=%0b first=m%0d", v.r0, v.a0, v.w0,
             v.r1, v.a1, v.w1, v.first);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0;
    t0_irq = 0; t1_irq = 0; d2_irq = 0;
    dev_rd[0] = 32'hA5A5_0001; dev_rd[1] = 32'h0000_1234; dev_rd[2] = 32'hD2D2_0002;
    t0_rdata = dev_rd[0]; t1_rdata = dev_rd[1]; d2_rdata = dev_rd[2];

    //            r0 r1 a0            w0 d0      a1            w1 d1        1st s0      s1      rd0           rd1           u0 u1
    tbl[0] = '{1, 1, 32'h7F04,     0, 32'h0,  32'h7F24,     1, 32'h55,   0, 3'b000, 3'b100, 32'hA5A50001, 32'h0,        0, 0};
    tbl[1] = '{1, 0, 32'h7F00,     1, 32'h9,  32'h0,        0, 32'h0,    0, 3'b001, 3'b000, 32'h0,        32'h0,        0, 0};
    tbl[2] = '{1, 1, 32'h7F14,     1, 32'h77, 32'h7F28,     0, 32'h0,    1, 3'b010, 3'b000, 32'h0,        32'hD2D20002, 0, 0};
    tbl[3] = '{0, 1, 32'h0,        0, 32'h0,  32'h7F18,     0, 32'h0,    1, 3'b000, 3'b000, 32'h0,        32'h1234,     0, 0};
    tbl[4] = '{1, 0, 32'h7F40,     0, 32'h0,  32'h0,        0, 32'h0,    0, 3'b000, 3'b000, 32'h0,        32'h0,        1, 0};
    tbl[5] = '{0, 1, 32'h0,        0, 32'h0,  32'h12347F00, 1, 32'hDEAD, 1, 3'b000, 3'b000, 32'h0,        32'h0,        0, 1};
    tbl[6] = '{1, 1, 32'h7F0C,     0, 32'h0,  32'h7F3C,     0, 32'h0,    0, 3'b000, 3'b000, 32'hA5A50001, 32'h0,        0, 1};
    tbl[7] = '{0, 1, 32'h0,        0, 32'h0,  32'h7F2C,     1, 32'hCAFE, 1, 3'b000, 3'b100, 32'h0,        32'h0,        0, 0};

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_quiet("idle");

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset landing in ACCESS of a write: strobe masked, no ack afterwards.
    m0_req = 1; m0_addr = 32'h7F00; m0_we = 1; m0_wdata = 32'hBEEF;
    @(posedge clk); #1;
    check("pre-reset t0_we", {31'd0, t0_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset t0_we", {31'd0, t0_we}, 32'd0);
    m0_req = 0;
    @(posedge clk); #1;
    check_quiet("midreset");
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post-reset acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      check("post-reset strobes", {29'd0, d2_we, t1_we, t0_we}, 32'd0);
    end
    $display("reset-in-access sequence done");
    hold_rd0 = 32'h0; hold_rd1 = 32'h0; last_m1 = 1'b1;

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      int   k0, k1;
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      for (int d = 0; d < 3; d++) dev_rd[d] = $urandom;
      t0_rdata = dev_rd[0]; t1_rdata = dev_rd[1]; d2_rdata = dev_rd[2];
      v.r0 = rq[0]; v.r1 = rq[1];
      v.a0 = rand_addr(); v.w0 = 1'($urandom_range(0, 1)); v.d0 = $urandom;
      v.a1 = rand_addr(); v.w1 = 1'($urandom_range(0, 1)); v.d1 = $urandom;
      k0 = win(v.a0); k1 = win(v.a1);
      if (v.r0 && v.r1) v.first = ~last_m1;
      else              v.first = v.r1;
      last_m1 = (v.r0 && v.r1) ? ~v.first : v.first;
      v.u0  = (k0 == 3);
      v.u1  = (k1 == 3);
      v.s0  = (v.w0 && k0 < 3) ? 3'(1 << k0) : 3'b000;
      v.s1  = (v.w1 && k1 < 3) ? 3'(1 << k1) : 3'b000;
      v.rd0 = (!v.w0 && k0 < 3) ? dev_rd[k0] : 32'h0;
      v.rd1 = (!v.w1 && k1 < 3) ? dev_rd[k1] : 32'h0;
      run_vec(v);
    end

    // Interrupt registration: each pattern appears one edge later.
    for (int p = 1; p < 8; p++) begin
      logic [5:0] prev;
      logic [2:0] pat;
      prev = hwint;
      pat  = 3'(p);
      {d2_irq, t1_irq, t0_irq} = pat;
      #1;
      check("hwint before edge", {26'd0, hwint}, {26'd0, prev});
      @(posedge clk); #1;
      check("hwint", {26'd0, hwint}, {29'd0, pat});
      $display("irq pattern %b -> hwint %b", pat, hwint);
    end
    {d2_irq, t1_irq, t0_irq} = 3'b000;
    @(posedge clk); #1;
    check("hwint clear", {26'd0, hwint}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
